// File: rtl/mcd_io_ctl_pkg.sv
// Shared address map, command bit positions and status packing for the Mega-CD host control block.
package mcd_pkg;

    localparam logic [15:0] CFG_BASE    = 16'hFF00;
    localparam logic [15:0] PHA_ADDR    = 16'hFF20;
    localparam logic [15:0] PHA_LO_ADDR = 16'hFF21;
    localparam logic [15:0] CMD_ADDR    = 16'h8010;
    localparam logic [15:0] STAT_ADDR   = 16'h8011;
    localparam logic [15:0] MCLR_ADDR   = 16'h8012;

    localparam int CMD_IRQ_BIT  = 0;
    localparam int CMD_MUTE_LSB = 1;

    // Status byte: {ovf, pending, armed, mute[4:0]}; mute channels beyond 5 are not visible here.
    function automatic logic [7:0] status_byte(input logic ovf, input logic pending,
                                               input logic armed, input logic [4:0] mute);
        status_byte = {ovf, pending, armed, mute};
    endfunction

endpackage

// File: rtl/mcd_io_ctl_if.sv
// PI-bus side and core-side signal bundle of the Mega-CD control block.
interface mcd_io_ctl_if #(
    parameter int DSP_BYTES = 8,
    parameter int MUTE_CH   = 2,
    parameter int PHA_W     = 12
);
    logic                   ce_mcd;
    logic [15:0]            addr;
    logic [7:0]             dato;
    logic                   we_sync;
    logic                   oe_sync;
    logic                   us_tick;
    logic                   frame_tick;
    logic                   ce_cdc;
    logic                   ce_cdd;
    logic                   mcd_irq;
    logic [MUTE_CH-1:0]     mute;
    logic                   mcd_rack;
    logic [8*DSP_BYTES-1:0] cfg_dsp;
    logic [PHA_W-1:0]       cfg_pha;
    logic [7:0]             rd_dat;

    modport slave (
        input  ce_mcd, addr, dato, we_sync, oe_sync, us_tick, frame_tick,
        output ce_cdc, ce_cdd, mcd_irq, mute, mcd_rack, cfg_dsp, cfg_pha, rd_dat
    );

    modport master (
        output ce_mcd, addr, dato, we_sync, oe_sync, us_tick, frame_tick,
        input  ce_cdc, ce_cdd, mcd_irq, mute, mcd_rack, cfg_dsp, cfg_pha, rd_dat
    );
endinterface

// File: rtl/mcd_io_ctl_irq_sched.sv
// Frame-synchronised IRQ scheduler: phase counter after frame_tick, pending/overflow tracking, IRQ pulse.
module mcd_irq_sched #(
    parameter int PHA_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_tick_i,
    input  logic             us_tick_i,
    input  logic             req_i,
    input  logic             ovf_clr_i,
    input  logic [PHA_W-1:0] pha_i,
    output logic             irq_o,
    output logic             pending_o,
    output logic             armed_o,
    output logic             ovf_o
);
    logic [PHA_W-1:0] cnt_q, cnt_d;
    logic             armed_q, armed_d;
    logic             pending_q, pending_d;
    logic             ovf_q, ovf_d;
    logic             irq_q, irq_d;
    logic             fire;

    always_comb begin
        fire      = armed_q && pending_q && (cnt_q == pha_i) && !frame_tick_i;
        cnt_d     = cnt_q;
        armed_d   = armed_q;
        pending_d = pending_q;
        ovf_d     = ovf_q;
        irq_d     = fire;

        if (frame_tick_i) begin
            cnt_d   = '0;
            armed_d = 1'b1;
        end else begin
            if (armed_q && us_tick_i && (cnt_q != '1))
                cnt_d = cnt_q + 1'b1;
            // Once the window has gone by, a late request must wait for the next frame.
            if (fire || (armed_q && (cnt_q > pha_i)))
                armed_d = 1'b0;
        end

        // A request arriving on the fire cycle survives as the new pending one.
        if (fire) begin
            pending_d = req_i;
        end else if (req_i) begin
            pending_d = 1'b1;
            if (pending_q)
                ovf_d = 1'b1;
        end

        if (ovf_clr_i)
            ovf_d = 1'b0;
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            armed_q   <= 1'b0;
            pending_q <= 1'b0;
            ovf_q     <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            armed_q   <= armed_d;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
            irq_q     <= irq_d;
        end
    end

    assign irq_o     = irq_q;
    assign pending_o = pending_q;
    assign armed_o   = armed_q;
    assign ovf_o     = ovf_q;
endmodule

// File: rtl/mcd_io_ctl.sv
// Mega-CD host control I/O: PI-bus decode, DSP/phase config registers, mute latches and readback.
module mcd_io_ctl
    import mcd_pkg::*;
#(
    parameter int DSP_BYTES = 8,
    parameter int MUTE_CH   = 2,
    parameter int PHA_W     = 12,
    parameter int PHA_DEF   = 350,
    parameter int CDC_LEN   = 2352,
    parameter int CDD_LEN   = 5
) (
    input logic         clk,
    input logic         rst,
    mcd_io_ctl_if.slave bus
);
    localparam logic [14:0]      CDC_LIM = 15'(CDC_LEN);
    localparam logic [14:0]      CDD_LIM = 15'(CDD_LEN);
    localparam logic [PHA_W-1:0] PHA_RST = PHA_W'(PHA_DEF);

    logic [DSP_BYTES-1:0][7:0] dsp_q, dsp_d;
    logic [PHA_W-1:0]          pha_q, pha_d;
    logic [MUTE_CH-1:0]        mute_q, mute_d;
    logic                      rack_q, rack_d;
    logic [7:0]                rd_q, rd_d;
    logic [7:0]                rd_mux;
    logic                      wr, rd, req, ovf_clr;
    logic                      pending, armed, ovf, irq;

    assign wr      = bus.we_sync && bus.ce_mcd;
    assign rd      = bus.oe_sync && bus.ce_mcd;
    assign req     = wr && (bus.addr == CMD_ADDR) && bus.dato[CMD_IRQ_BIT];
    assign ovf_clr = wr && (bus.addr == STAT_ADDR);

    assign bus.ce_cdc = bus.ce_mcd && !bus.addr[15] && (bus.addr[14:0] < CDC_LIM);
    assign bus.ce_cdd = bus.ce_mcd &&  bus.addr[15] && (bus.addr[14:0] < CDD_LIM);

    always_comb begin
        dsp_d  = dsp_q;
        pha_d  = pha_q;
        mute_d = mute_q;
        rack_d = 1'b0;
        if (wr) begin
            for (int i = 0; i < DSP_BYTES; i++)
                if (bus.addr == CFG_BASE + 16'(i))
                    dsp_d[i] = bus.dato;
            if (bus.addr == PHA_ADDR)
                pha_d[PHA_W-1:8] = bus.dato[PHA_W-9:0];
            if (bus.addr == PHA_LO_ADDR)
                pha_d[7:0] = bus.dato;
            if (bus.addr == CMD_ADDR) begin
                mute_d = mute_q | bus.dato[MUTE_CH:CMD_MUTE_LSB];
                rack_d = bus.dato[MUTE_CH+1];
            end
            if (bus.addr == MCLR_ADDR)
                mute_d = mute_q & ~bus.dato[MUTE_CH-1:0];
        end
        // A zero phase is never kept: it falls back to the default on the following cycle.
        if (pha_q == '0)
            pha_d = PHA_RST;
    end

    always_comb begin
        rd_mux = 8'h00;
        for (int i = 0; i < DSP_BYTES; i++)
            if (bus.addr == CFG_BASE + 16'(i))
                rd_mux = dsp_q[i];
        if (bus.addr == PHA_ADDR)
            rd_mux = 8'(pha_q[PHA_W-1:8]);
        if (bus.addr == PHA_LO_ADDR)
            rd_mux = pha_q[7:0];
        if (bus.addr == STAT_ADDR)
            rd_mux = status_byte(ovf, pending, armed, 5'(mute_q));
        rd_d = rd ? rd_mux : rd_q;
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            dsp_q  <= '0;
            pha_q  <= PHA_RST;
            mute_q <= '0;
            rack_q <= 1'b0;
            rd_q   <= 8'h00;
        end else begin
            dsp_q  <= dsp_d;
            pha_q  <= pha_d;
            mute_q <= mute_d;
            rack_q <= rack_d;
            rd_q   <= rd_d;
        end
    end

    mcd_irq_sched #(.PHA_W(PHA_W)) u_sched (
        .clk          (clk),
        .rst          (rst),
        .frame_tick_i (bus.frame_tick),
        .us_tick_i    (bus.us_tick),
        .req_i        (req),
        .ovf_clr_i    (ovf_clr),
        .pha_i        (pha_q),
        .irq_o        (irq),
        .pending_o    (pending),
        .armed_o      (armed),
        .ovf_o        (ovf)
    );

    assign bus.mcd_irq  = irq;
    assign bus.mute     = mute_q;
    assign bus.mcd_rack = rack_q;
    assign bus.cfg_dsp  = dsp_q;
    assign bus.cfg_pha  = pha_q;
    assign bus.rd_dat   = rd_q;
endmodule

// File: tb/tb_mcd_io_ctl.sv
// Directed bench for mcd_io_ctl: config regs, phase reload, IRQ scheduling, mute/rack, decode, reset.
module tb_mcd_io_ctl;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    int   irq_cnt;
    logic [7:0] d;

    mcd_io_ctl_if #(.DSP_BYTES(8), .MUTE_CH(2), .PHA_W(12)) bus ();

    mcd_io_ctl #(
        .DSP_BYTES(8), .MUTE_CH(2), .PHA_W(12),
        .PHA_DEF(350), .CDC_LEN(2352), .CDD_LEN(5)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    initial irq_cnt = 0;
    always @(posedge clk) if (bus.mcd_irq === 1'b1) irq_cnt = irq_cnt + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] v);
        bus.ce_mcd = 1'b1; bus.addr = a; bus.dato = v; bus.we_sync = 1'b1;
        step();
        bus.we_sync = 1'b0; bus.ce_mcd = 1'b0;
    endtask

    task automatic rdb(input logic [15:0] a, output logic [7:0] v);
        bus.ce_mcd = 1'b1; bus.addr = a; bus.oe_sync = 1'b1;
        step();
        bus.oe_sync = 1'b0; bus.ce_mcd = 1'b0;
        v = bus.rd_dat;
    endtask

    task automatic us_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            bus.us_tick = 1'b1;
            step();
            bus.us_tick = 1'b0;
            step();
            step();
        end
    endtask

    task automatic frame();
        bus.frame_tick = 1'b1;
        step();
        bus.frame_tick = 1'b0;
        step();
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        bus.ce_mcd = 0; bus.addr = 0; bus.dato = 0; bus.we_sync = 0;
        bus.oe_sync = 0; bus.us_tick = 0; bus.frame_tick = 0;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();

        check("rst_cfg_dsp", bus.cfg_dsp, 64'h0);
        check("rst_cfg_pha", bus.cfg_pha, 64'd350);
        check("rst_mute", bus.mute, 64'h0);
        check("rst_rd_dat", bus.rd_dat, 64'h0);
        check("rst_irq", bus.mcd_irq, 64'h0);
        check("rst_rack", bus.mcd_rack, 64'h0);

        // Phase readback and zero-write fallback
        rdb(16'hFF20, d); check("pha_hi_rst", d, 64'h01);
        rdb(16'hFF21, d); check("pha_lo_rst", d, 64'h5E);
        wr(16'hFF20, 8'h00);
        wr(16'hFF21, 8'h00);
        step();
        check("pha_reload", bus.cfg_pha, 64'd350);
        rdb(16'hFF20, d); check("pha_hi_reload", d, 64'h01);
        rdb(16'hFF21, d); check("pha_lo_reload", d, 64'h5E);

        // DSP config bytes, alias above DSP_BYTES ignored
        wr(16'hFF03, 8'hA5);
        wr(16'hFF0B, 8'h11);
        check("cfg_dsp", bus.cfg_dsp, 64'h00000000_A5000000);
        rdb(16'hFF03, d); check("rd_dsp3", d, 64'hA5);
        rdb(16'hFF0B, d); check("rd_alias", d, 64'h00);

        // IRQ scheduled at phase 10
        wr(16'hFF20, 8'h00);
        wr(16'hFF21, 8'h0A);
        check("pha_10", bus.cfg_pha, 64'd10);
        frame();
        us_ticks(3);
        wr(16'h8010, 8'h01);
        us_ticks(6);
        check("irq_before_phase", irq_cnt, 64'd0);
        us_ticks(1);
        check("irq_at_phase", irq_cnt, 64'd1);
        us_ticks(5);
        frame();
        us_ticks(15);
        check("irq_no_repeat", irq_cnt, 64'd1);

        // Late request waits for the next frame
        frame();
        us_ticks(20);
        wr(16'h8010, 8'h01);
        rdb(16'h8011, d); check("stat_late_pending", d, 64'h40);
        us_ticks(5);
        check("irq_late_none", irq_cnt, 64'd1);
        frame();
        us_ticks(9);
        check("irq_next_before", irq_cnt, 64'd1);
        us_ticks(1);
        check("irq_next_frame", irq_cnt, 64'd2);
        rdb(16'h8011, d); check("stat_after_fire", d, 64'h00);

        // Overflow on double request, cleared by 0x8011 write
        wr(16'h8010, 8'h01);
        wr(16'h8010, 8'h01);
        rdb(16'h8011, d); check("stat_ovf", d, 64'hC0);
        wr(16'h8011, 8'h00);
        rdb(16'h8011, d); check("stat_ovf_clr", d, 64'h40);

        // Mute set, rack pulse, mute clear
        wr(16'h8010, 8'h0E);
        check("mute_set", bus.mute, 64'h3);
        check("rack_hi", bus.mcd_rack, 64'h1);
        step();
        check("rack_lo", bus.mcd_rack, 64'h0);
        rdb(16'h8011, d); check("stat_mute", d, 64'h43);
        wr(16'h8012, 8'h01);
        check("mute_clr", bus.mute, 64'h2);

        // Chip-enable decode
        bus.ce_mcd = 1'b1;
        bus.addr = 16'h092F; #1;
        check("cdc_last", {bus.ce_cdc, bus.ce_cdd}, 64'h2);
        bus.addr = 16'h0930; #1;
        check("cdc_past", {bus.ce_cdc, bus.ce_cdd}, 64'h0);
        bus.addr = 16'h8004; #1;
        check("cdd_last", {bus.ce_cdc, bus.ce_cdd}, 64'h1);
        bus.addr = 16'h8005; #1;
        check("cdd_past", {bus.ce_cdc, bus.ce_cdd}, 64'h0);
        bus.ce_mcd = 1'b0;
        bus.addr = 16'h0000; #1;
        check("ce_off", {bus.ce_cdc, bus.ce_cdd}, 64'h0);
        step();

        // Reset mid-frame: state cleared, no IRQ without a new frame
        frame();
        us_ticks(3);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        check("rst2_pha", bus.cfg_pha, 64'd350);
        check("rst2_mute", bus.mute, 64'h0);
        check("rst2_dsp", bus.cfg_dsp, 64'h0);
        rdb(16'h8011, d); check("rst2_stat", d, 64'h00);
        wr(16'hFF20, 8'h00);
        wr(16'hFF21, 8'h0A);
        wr(16'h8010, 8'h01);
        us_ticks(12);
        check("rst2_no_irq", irq_cnt, 64'd2);
        rdb(16'h8011, d); check("rst2_pending", d, 64'h40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
